btn_counter: RTL

Upstream value source for the four-digit seven-segment driver on the Nexys3. It synchronises and debounces three raw push-buttons (up, down, clear) and maintains a 9-bit up/down count presented as `nb`. It also generates the divided display-scan clock `myclk` that clocks the display driver. All logic runs in the 100 MHz board clock domain.

---
 rtl/btn_counter_pkg.sv | 16 +
 rtl/btn_debounce.sv | 54 +++++
 rtl/btn_counter.sv | 89 ++++++++
 3 files changed

// File: rtl/btn_counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_counter_pkg : shared widths, default constants and count type
// Rev 1.0
// ---------------------------------------------------------------------------
package btn_counter_pkg;

  localparam int NB_W           = 9;
  localparam int DEB_CYCLES_DEF = 500000;
  localparam int DIV_HALF_DEF   = 50000;
  localparam int MAX_VAL_DEF    = 511;

  typedef logic [NB_W-1:0] nb_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_debounce : 2-flop synchroniser, hold-time debouncer and press detect
// Rev 1.0
// ---------------------------------------------------------------------------
module btn_debounce
  import btn_counter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic stable,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      stable_d <= stable;
      // Any sample agreeing with the accepted level restarts the hold timer.
      if (s2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule
`default_nettype wire

// File: rtl/btn_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_counter : debounced up/down/clear 9-bit counter and display scan clock
// Rev 1.0
// ---------------------------------------------------------------------------
module btn_counter
  import btn_counter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DIV_HALF   = DIV_HALF_DEF,
  parameter int MAX_VAL    = MAX_VAL_DEF,
  parameter int WRAP       = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            btn_clr,
  output logic [NB_W-1:0] nb,
  output logic            myclk,
  output logic            lim
);

  localparam nb_t             MAX_NB   = nb_t'(MAX_VAL);
  localparam int              DIV_W    = $clog2(DIV_HALF + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);

  logic stable_up, stable_down, stable_clr;
  logic deb_up, deb_down, deb_clr;
  logic press_up, press_down, press_clr;
  logic [DIV_W-1:0] div;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .stable(stable_up), .press(deb_up)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst_n(rst_n), .btn(btn_down), .stable(stable_down), .press(deb_down)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk(clk), .rst_n(rst_n), .btn(btn_clr), .stable(stable_clr), .press(deb_clr)
  );

  // A press already implies the stable level is high; the qualifier is free.
  assign press_up   = deb_up   & stable_up;
  assign press_down = deb_down & stable_down;
  assign press_clr  = deb_clr  & stable_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nb  <= '0;
      lim <= 1'b0;
    end else begin
      lim <= 1'b0;
      if (press_clr) begin
        nb <= '0;
      end else if (press_up && press_down) begin
        nb <= nb;
      end else if (press_up) begin
        if (nb == MAX_NB) begin
          nb  <= (WRAP != 0) ? '0 : MAX_NB;
          lim <= 1'b1;
        end else begin
          nb <= nb + 1'b1;
        end
      end else if (press_down) begin
        if (nb == '0) begin
          nb  <= (WRAP != 0) ? MAX_NB : '0;
          lim <= 1'b1;
        end else begin
          nb <= nb - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div   <= '0;
      myclk <= 1'b0;
    end else if (div == DIV_LAST) begin
      div   <= '0;
      myclk <= ~myclk;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule
`default_nettype wire
